// File: rtl/bitwave_pkg.sv
// Shared widths, FSM state type and helper for the bit-column weight encoder.
package bitwave_pkg;
  localparam int DATA_WIDTH    = 8;
  localparam int VEC_LENGTH    = 16;
  localparam int MAG_WIDTH     = DATA_WIDTH - 1;
  localparam int COL_IDX_WIDTH = 3;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // All-zero groups still cost one beat, so they report 6 skipped columns, not 7.
  function automatic logic [COL_IDX_WIDTH-1:0] skip_count(input logic [MAG_WIDTH-1:0] m);
    int n;
    n = 0;
    for (int k = 0; k < MAG_WIDTH; k++) n += int'(m[k]);
    if (n == 0) return COL_IDX_WIDTH'(6);
    return COL_IDX_WIDTH'(MAG_WIDTH - n);
  endfunction
endpackage

// File: rtl/col_priority_enc.sv
// Highest-set-bit encoder over the 7-bit column mask.
module col_priority_enc
  import bitwave_pkg::*;
(
  input  logic [MAG_WIDTH-1:0]     mask_i,
  output logic [COL_IDX_WIDTH-1:0] idx_o,
  output logic                     any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int k = 0; k < MAG_WIDTH; k++) begin
      if (mask_i[k]) idx_o = COL_IDX_WIDTH'(k);
    end
  end
endmodule

// File: rtl/bitwave_col_encoder_16.sv
// Sign-magnitude bit-column encoder: streams only the non-zero magnitude columns
// of a 16-lane weight group, MSB column first, with valid/ready on both sides.
module bitwave_col_encoder_16 #(
  parameter int DATA_WIDTH = bitwave_pkg::DATA_WIDTH,
  parameter int VEC_LENGTH = bitwave_pkg::VEC_LENGTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic signed [DATA_WIDTH-1:0]          w_in [VEC_LENGTH],
  input  logic                                  w_valid,
  output logic                                  w_ready,
  output logic [VEC_LENGTH-1:0]                 sign,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic [bitwave_pkg::COL_IDX_WIDTH-1:0] column_idx,
  output logic                                  load_accum,
  output logic                                  col_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [bitwave_pkg::COL_IDX_WIDTH-1:0] skipped_cols
);
  import bitwave_pkg::*;

  localparam int MW = DATA_WIDTH - 1;

  // -128 has no positive counterpart in MW bits; clamp it to the largest magnitude.
  function automatic logic [MW-1:0] sat_abs(input logic signed [DATA_WIDTH-1:0] w);
    logic signed [DATA_WIDTH-1:0] neg;
    if (!w[DATA_WIDTH-1]) return w[MW-1:0];
    if (w == {1'b1, {MW{1'b0}}}) return {MW{1'b1}};
    neg = -w;
    return neg[MW-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [VEC_LENGTH-1:0]    sign_q, sign_d;
  logic [VEC_LENGTH-1:0]    w_bit_q, w_bit_d;
  logic [COL_IDX_WIDTH-1:0] col_q, col_d;
  logic [COL_IDX_WIDTH-1:0] skip_q, skip_d;
  logic                     load_q, load_d;
  logic                     last_q, last_d;
  logic                     vld_q, vld_d;
  logic [MW-1:0]            rem_q, rem_d;
  logic [MW-1:0]            mag_q [VEC_LENGTH];

  logic [MW-1:0]            mag_in [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]    sign_in;
  logic [MW-1:0]            mask_in;
  logic [MW-1:0]            enc_mask, cleared;
  logic [COL_IDX_WIDTH-1:0] enc_idx;
  logic                     enc_any;
  logic                     handshake, accept;

  always_comb begin
    mask_in = '0;
    sign_in = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      sign_in[j] = w_in[j][DATA_WIDTH-1];
      mag_in[j]  = sat_abs(w_in[j]);
      mask_in    = mask_in | mag_in[j];
    end
  end

  assign handshake = vld_q & out_ready;
  assign w_ready   = !reset & ((state_q == IDLE) | (handshake & last_q));
  assign accept    = w_valid & w_ready;

  // A new group is only taken when the remaining mask is already empty, so one
  // encoder serves both the first column of a new group and the following ones.
  assign enc_mask = accept ? mask_in : rem_q;
  assign cleared  = enc_mask & ~(MW'(1) << enc_idx);

  col_priority_enc u_enc (
    .mask_i (enc_mask),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    w_bit_d = w_bit_q;
    col_d   = col_q;
    skip_d  = skip_q;
    load_d  = load_q;
    last_d  = last_q;
    vld_d   = vld_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (handshake && last_q) state_d = accept ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sign_d = sign_in;
      skip_d = skip_count(mask_in);
      col_d  = enc_any ? enc_idx : '0;
      for (int j = 0; j < VEC_LENGTH; j++) w_bit_d[j] = mag_in[j][enc_idx];
      load_d = 1'b1;
      last_d = (cleared == '0);
      rem_d  = cleared;
      vld_d  = 1'b1;
    end else if (handshake) begin
      if (last_q) begin
        vld_d  = 1'b0;
        load_d = 1'b0;
        last_d = 1'b0;
      end else begin
        col_d  = enc_idx;
        for (int j = 0; j < VEC_LENGTH; j++) w_bit_d[j] = mag_q[j][enc_idx];
        load_d = 1'b0;
        last_d = (cleared == '0);
        rem_d  = cleared;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= '0;
      w_bit_q <= '0;
      col_q   <= '0;
      skip_q  <= '0;
      load_q  <= 1'b0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      w_bit_q <= w_bit_d;
      col_q   <= col_d;
      skip_q  <= skip_d;
      load_q  <= load_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      rem_q   <= rem_d;
    end
  end

  // Magnitudes are pure data: only read while a group is streaming.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < VEC_LENGTH; j++) mag_q[j] <= mag_in[j];
    end
  end

  assign sign         = sign_q;
  assign w_bit        = w_bit_q;
  assign column_idx   = col_q;
  assign load_accum   = load_q;
  assign col_last     = last_q;
  assign out_valid    = vld_q;
  assign skipped_cols = skip_q;
endmodule

// File: tb/tb_bitwave_col_encoder_16.sv
// Directed-vector bench for bitwave_col_encoder_16 with hand-computed beats.
module tb_bitwave_col_encoder_16;
  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] w_in [16];
  logic              w_valid;
  logic              w_ready;
  logic [15:0]       sign;
  logic [15:0]       w_bit;
  logic [2:0]        column_idx;
  logic              load_accum;
  logic              col_last;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        skipped_cols;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bitwave_col_encoder_16 dut (
    .clk          (clk),
    .reset        (reset),
    .w_in         (w_in),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .sign         (sign),
    .w_bit        (w_bit),
    .column_idx   (column_idx),
    .load_accum   (load_accum),
    .col_last     (col_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .skipped_cols (skipped_cols)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [7:0] v);
    for (int j = 0; j < 16; j++) w_in[j] = v;
  endtask

  task automatic beat(input string tag, input int col, input logic [15:0] wb,
                      input logic ld, input logic ls);
    chk({tag, ".vld"},  32'(out_valid),  32'd1);
    chk({tag, ".col"},  32'(column_idx), 32'(col));
    chk({tag, ".wbit"}, 32'(w_bit),      32'(wb));
    chk({tag, ".load"}, 32'(load_accum), 32'(ld));
    chk({tag, ".last"}, 32'(col_last),   32'(ls));
  endtask

  int exp_col;
  int nbeats;
  logic rdy;
  logic [3:0] pat;

  initial begin
    reset = 1'b1;
    w_valid = 1'b0;
    out_ready = 1'b1;
    set_all(8'sd0);
    #12;
    chk("rst.vld",   32'(out_valid),    32'd0);
    chk("rst.ready", 32'(w_ready),      32'd0);
    chk("rst.sign",  32'(sign),         32'd0);
    chk("rst.wbit",  32'(w_bit),        32'd0);
    chk("rst.skip",  32'(skipped_cols), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle.ready", 32'(w_ready), 32'd1);

    // All weights 5: columns 2 and 0
    set_all(8'sd5);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    beat("w5.b0", 2, 16'hFFFF, 1'b1, 1'b0);
    chk("w5.skip", 32'(skipped_cols), 32'd5);
    chk("w5.sign", 32'(sign),         32'd0);
    chk("w5.ready_mid", 32'(w_ready), 32'd0);
    step();
    beat("w5.b1", 0, 16'hFFFF, 1'b0, 1'b1);
    step();
    chk("w5.done", 32'(out_valid), 32'd0);
    chk("w5.ready_end", 32'(w_ready), 32'd1);

    // Lane0 = -128 saturates to 127: seven beats
    set_all(8'sd0);
    w_in[0] = -8'sd128;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    chk("m128.sign", 32'(sign),         32'h0001);
    chk("m128.skip", 32'(skipped_cols), 32'd0);
    for (int k = 6; k >= 0; k--) begin
      beat($sformatf("m128.c%0d", k), k, 16'h0001, k == 6, k == 0);
      step();
    end
    chk("m128.done", 32'(out_valid), 32'd0);

    // All-zero group: single beat at column 0
    set_all(8'sd0);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    beat("zero", 0, 16'h0000, 1'b1, 1'b1);
    chk("zero.skip", 32'(skipped_cols), 32'd6);
    step();
    chk("zero.done", 32'(out_valid), 32'd0);

    // Mixed lanes w[j] = j-8: columns 3..0
    for (int j = 0; j < 16; j++) w_in[j] = 8'(j - 8);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    chk("mix.sign", 32'(sign),         32'h00FF);
    chk("mix.skip", 32'(skipped_cols), 32'd3);
    beat("mix.c3", 3, 16'h0001, 1'b1, 1'b0);
    step();
    beat("mix.c2", 2, 16'hF01E, 1'b0, 1'b0);
    step();
    beat("mix.c1", 1, 16'hCC66, 1'b0, 1'b0);
    step();
    beat("mix.c0", 0, 16'hAAAA, 1'b0, 1'b1);
    step();
    chk("mix.done", 32'(out_valid), 32'd0);

    // Back-to-back groups 0x40 then 0x01 with w_valid held
    set_all(8'sh40);
    w_valid = 1'b1;
    step();
    beat("b2b.c6", 6, 16'hFFFF, 1'b1, 1'b1);
    chk("b2b.ready", 32'(w_ready), 32'd1);
    set_all(8'sh01);
    step();
    w_valid = 1'b0;
    beat("b2b.c0", 0, 16'hFFFF, 1'b1, 1'b1);
    chk("b2b.skip", 32'(skipped_cols), 32'd6);
    step();
    chk("b2b.done", 32'(out_valid), 32'd0);

    // 0x7F with out_ready pattern 1,0,0,1
    set_all(8'sh7F);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    pat = 4'b1001;
    exp_col = 6;
    nbeats = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!out_valid) break;
      beat($sformatf("stall.%0d", cyc), exp_col, 16'hFFFF, exp_col == 6, exp_col == 0);
      rdy = pat[cyc % 4];
      out_ready = rdy;
      step();
      if (rdy) begin
        nbeats++;
        exp_col--;
      end
    end
    out_ready = 1'b1;
    chk("stall.count", 32'(nbeats), 32'd7);
    chk("stall.done",  32'(out_valid), 32'd0);

    // Reset mid-group, then a fresh 0x03 group
    set_all(8'sh7F);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    beat("mid.c6", 6, 16'hFFFF, 1'b1, 1'b0);
    step();
    step();
    beat("mid.c4", 4, 16'hFFFF, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid.rst.vld",   32'(out_valid),  32'd0);
    chk("mid.rst.col",   32'(column_idx), 32'd0);
    chk("mid.rst.wbit",  32'(w_bit),      32'd0);
    chk("mid.rst.last",  32'(col_last),   32'd0);
    chk("mid.rst.ready", 32'(w_ready),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.ready", 32'(w_ready), 32'd1);
    set_all(8'sh03);
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    beat("post.c1", 1, 16'hFFFF, 1'b1, 1'b0);
    chk("post.skip", 32'(skipped_cols), 32'd5);
    step();
    beat("post.c0", 0, 16'hFFFF, 1'b0, 1'b1);
    step();
    chk("post.done", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bitwave_col_encoder_16.md
BITWAVE_COL_ENCODER_16 -- requirements
Module: bitwave_col_encoder_16

Interface
REQ-001 Parameter DATA_WIDTH, 8, two's-complement weight width; magnitude width MAG_WIDTH = DATA_WIDTH-1 = 7.
REQ-002 Parameter VEC_LENGTH, 16, weights per group (lanes).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 w_in  input  signed DATA_WIDTH x VEC_LENGTH  weight group, lane j = w_in[j].
REQ-006 w_valid  input  1  w_in valid.
REQ-007 w_ready  output  1  encoder accepts w_in this cycle.
REQ-008 sign  output  1 x VEC_LENGTH  per-lane weight sign (1 = negative).
REQ-009 w_bit  output  1 x VEC_LENGTH  per-lane magnitude bit of the current column.
REQ-010 column_idx  output  3  bit-column (shift amount) of the current beat, 0..6.
REQ-011 load_accum  output  1  first beat of a group.
REQ-012 col_last  output  1  last beat of a group.
REQ-013 out_valid  output  1  beat valid.
REQ-014 out_ready  input  1  downstream MAC accepts beat.
REQ-015 skipped_cols  output  3  number of all-zero columns skipped in the group currently streaming.

Function
REQ-016 Conversion: sign[j] = w_in[j] < 0; mag[j] = |w_in[j]|; -128 SHALL saturate to magnitude 127 (sign 1).
REQ-017 On acceptance (w_valid & w_ready) the block SHALL register sign, mag, and column mask M[k] = OR over lanes of mag[j][k], k = 0..6.
REQ-018 FSM states: IDLE, STREAM; IDLE -> STREAM on acceptance; STREAM -> IDLE on handshake of a col_last beat without simultaneous acceptance; STREAM -> STREAM on handshake of a col_last beat with simultaneous acceptance.
REQ-019 w_ready SHALL be 1 in IDLE, and 1 in STREAM only in a cycle where out_valid & out_ready & col_last; 0 otherwise and while reset is asserted.
REQ-020 Latency: first out_valid SHALL rise the cycle after acceptance; no idle cycles between beats or groups while out_ready = 1.
REQ-021 Beats SHALL emit set columns of M in descending order (6 down to 0), one per handshake; zero columns are never emitted.
REQ-022 Per beat: column_idx = k, w_bit[j] = mag[j][k], sign[j] = registered sign; load_accum = 1 only on first beat, col_last = 1 only on the lowest set column.
REQ-023 All-zero group (M = 0): exactly one beat, column_idx = 0, w_bit all 0, load_accum = col_last = 1.
REQ-024 Single set column: one beat with load_accum = col_last = 1.
REQ-025 While out_valid & !out_ready all beat outputs SHALL hold stable.
REQ-026 skipped_cols = 7 - popcount(M), clamped to 6 when M = 0; held constant for the group.
REQ-027 Next column SHALL be the highest set bit of remaining mask R; R clears the emitted bit on each handshake.

Reset
REQ-028 Reset asserted (any time, including mid-group) SHALL force within the same cycle: state IDLE, out_valid 0, sign/w_bit all 0, column_idx 0, load_accum 0, col_last 0, skipped_cols 0, R 0; the in-flight group is discarded.
REQ-029 First acceptance possible in the first clock edge after reset deasserts.

Structure
REQ-030 Shared package bitwave_pkg SHALL hold DATA_WIDTH, VEC_LENGTH, MAG_WIDTH, COL_IDX_WIDTH = 3 and the FSM state enum.
REQ-031 One sub-module col_priority_enc (7-bit mask -> 3-bit highest-set index plus any-set flag) SHALL be instantiated.
REQ-032 Outputs SHALL be driven from registers; only w_ready may be combinational.

Verification
REQ-033 Weights all = 5 (0b101), out_ready = 1 -> two beats: col 2 (load_accum=1, w_bit all 1), col 0 (col_last=1); skipped_cols = 5.
REQ-034 Lane0 = -128, others 0 -> sign[0]=1, beats cols 6..0 all w_bit[0]=1, 7 beats, skipped_cols = 0.
REQ-035 All weights 0 -> single beat col 0, w_bit 0, load_accum = col_last = 1, skipped_cols = 6.
REQ-036 Back-to-back groups 0x40 then 0x01 with w_valid held -> beats col 6 (first/last), then col 0 next cycle (first/last); w_ready high on col-6 handshake cycle.
REQ-037 Group 0x7F, out_ready toggled 1,0,0,1 -> outputs stable while stalled; 7 beats total, no duplicates or drops.
REQ-038 Reset asserted on third beat of group 0x7F -> out_valid 0 immediately; after release w_ready = 1, new group 0x03 streams cols 1,0.
